mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter TIMEOUT, default 255, bus wait cycles before abort.
REQ-002 i_clock  in  1  clock, all state on rising edge.
REQ-003 i_reset  in  1  reset, asynchronous, active-high.
REQ-004 i_flush  in  1  discard current operation.
REQ-005 i_isValid, i_regWrAddr (GPRAddr), i_regWrEnable  in  1/5/1  operation tags from EX/MEM.
REQ-006 i_result  in  32  ALU result, also the memory address.
REQ-007 i_memRdEnable, i_memWrEnable  in  1/1  load/store request.
REQ-008 i_memAccess  in  2  access size: BYTE, HALF, WORD (MemAccess type).
REQ-009 i_memUnsigned  in  1  zero-extend the load result.
REQ-010 i_memWrData  in  32  store data, right-aligned.
REQ-011 o_memAddr  out  32  word-aligned bus address ({i_result[31:2],2'b00}).
REQ-012 o_memRdEnable, o_memWrEnable  out  1/1  bus request, held until i_memReady.
REQ-013 o_memByteEnable  out  4  lane enables.
REQ-014 o_memWrData  out  32  lane-replicated store data.
REQ-015 i_memRdData, i_memReady  in  32/1  bus read data, transfer acknowledge.
REQ-016 o_isValid, o_regWrAddr, o_regWrEnable, o_regWrData  out  1/5/1/32  to MEM/WB register.
REQ-017 o_stall  out  1  freeze upstream stages and MEM/WB.
REQ-018 o_misaligned, o_busError  out  1/1  one-cycle exception pulses.

Function
REQ-019 Non-memory valid op passes through combinationally: o_regWrData=i_result, no bus request, o_stall=0.
REQ-020 FSM states IDLE, WAIT; only IDLE issues new requests.
REQ-021 IDLE plus valid aligned memory op plus !i_flush: assert request the same cycle; if i_memReady=1, complete with zero stall, stay IDLE; otherwise o_stall=1, go to WAIT.
REQ-022 WAIT: hold request, address, enables and data stable; o_stall=1; o_isValid=0 until completion.
REQ-023 WAIT plus i_memReady: complete this cycle, o_stall=0, o_isValid=1, next state IDLE.
REQ-024 Byte enables: BYTE 0001<<a[1:0]; HALF 0011<<{a[1],1'b0}; WORD 1111.
REQ-025 Store data: BYTE replicated x4, HALF replicated x2, WORD as-is.
REQ-026 Load data: i_memRdData>>(8*a[1:0]), then sign- or zero-extend from 8/16 bits per i_memUnsigned; WORD unchanged.
REQ-027 Misaligned (HALF with a[0]=1, WORD with a[1:0]!=0): no bus request, o_misaligned=1 one cycle, o_isValid=0.
REQ-028 Wait counter cleared on entry to WAIT, incremented each WAIT cycle; reaching TIMEOUT drops request, pulses o_busError, returns to IDLE, o_isValid=0.
REQ-029 Flush in IDLE: suppress the request and set o_isValid=0.
REQ-030 Flush in WAIT: transfer still completes, but o_isValid=0 at completion.
REQ-031 i_memReady outside a request is ignored.
REQ-032 Stores drive o_regWrEnable=0 regardless of input.

Reset
REQ-033 Asynchronous reset sets state IDLE, counter 0, flush-pending 0; requests, o_stall, o_isValid, o_misaligned and o_busError deassert immediately.
REQ-034 Reset during WAIT abandons the transfer without error pulse.

Structure
REQ-035 MemAccess enum, GPRAddr, Data and the MemState enum are defined in package Types.
REQ-036 Load extraction/extension is the sub-module mem_load_align; store lane logic stays inline.

Verification
REQ-037 Word load, addr 0x100, ready same cycle, rdData 0x11223344 -> no stall, regWrData 0x11223344.
REQ-038 Signed byte load, addr 0x103, ready after 3 cycles, rdData 0x80FFFFFF -> stall 3 cycles, regWrData 0xFFFFFF80.
REQ-039 Half store, addr 0x202, data 0xABCD -> byteEnable 1100, wrData 0xABCDABCD.
REQ-040 Word load, addr 0x101 -> o_misaligned pulse, no request, o_isValid=0.
REQ-041 No ready for 255 wait cycles -> o_busError pulse, request drops, IDLE.
REQ-042 Flush asserted in WAIT, ready 2 cycles later -> transfer completes, o_isValid=0; reset mid-WAIT -> request drops immediately.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types for the memory stage: access sizes, register/data widths and the bus FSM states.
package Types;
  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } MemAccess;

  typedef logic [4:0]  GPRAddr;
  typedef logic [31:0] Data;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } MemState;
endpackage

// File: rtl/mem_stage_load_align.sv
// Load data extraction: shifts the addressed lane down and sign/zero-extends byte and half loads.
module mem_load_align
  import Types::*;
(
  input  logic [31:0] i_rdData,
  input  logic [1:0]  i_offset,
  input  logic [1:0]  i_access,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);
  logic [31:0] w_sh;

  assign w_sh = i_rdData >> {i_offset, 3'b000};

  // Word loads are aligned, so the zero shift leaves the data unchanged.
  always_comb begin
    o_data = w_sh;
    case (MemAccess'(i_access))
      BYTE:    o_data = i_unsigned ? {24'd0, w_sh[7:0]}  : {{24{w_sh[7]}},  w_sh[7:0]};
      HALF:    o_data = i_unsigned ? {16'd0, w_sh[15:0]} : {{16{w_sh[15]}}, w_sh[15:0]};
      default: o_data = w_sh;
    endcase
  end
endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: issues load/store bus requests, waits for the acknowledge with a
// timeout, aligns load data and forwards results to MEM/WB.
module mem_stage
  import Types::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_flush,
  input  logic        i_isValid,
  input  logic [4:0]  i_regWrAddr,
  input  logic        i_regWrEnable,
  input  logic [31:0] i_result,
  input  logic        i_memRdEnable,
  input  logic        i_memWrEnable,
  input  logic [1:0]  i_memAccess,
  input  logic        i_memUnsigned,
  input  logic [31:0] i_memWrData,
  output logic [31:0] o_memAddr,
  output logic        o_memRdEnable,
  output logic        o_memWrEnable,
  output logic [3:0]  o_memByteEnable,
  output logic [31:0] o_memWrData,
  input  logic [31:0] i_memRdData,
  input  logic        i_memReady,
  output logic        o_isValid,
  output logic [4:0]  o_regWrAddr,
  output logic        o_regWrEnable,
  output logic [31:0] o_regWrData,
  output logic        o_stall,
  output logic        o_misaligned,
  output logic        o_busError
);
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

  MemState      r_state;
  logic [CW-1:0] r_cnt;
  logic         r_flushPend;
  logic [31:0]  r_result, r_wrData;
  logic [1:0]   r_access;
  logic         r_rd, r_wr, r_unsigned, r_regWrEnable;
  GPRAddr       r_regWrAddr;

  logic         w_wait, w_idle;
  logic [31:0]  w_result, w_wrDataIn, w_ldData;
  logic [1:0]   w_access;
  logic         w_rd, w_wr, w_unsigned, w_regWe, w_memOp, w_misal;
  GPRAddr       w_regAddr;
  logic         w_issue, w_timeout, w_done, w_req;

  assign w_idle = (r_state == IDLE);
  assign w_wait = (r_state == WAIT);

  // While waiting, everything the bus and writeback see comes from the captured operation.
  assign w_result   = w_wait ? r_result      : i_result;
  assign w_wrDataIn = w_wait ? r_wrData      : i_memWrData;
  assign w_access   = w_wait ? r_access      : i_memAccess;
  assign w_rd       = w_wait ? r_rd          : i_memRdEnable;
  assign w_wr       = w_wait ? r_wr          : i_memWrEnable;
  assign w_unsigned = w_wait ? r_unsigned    : i_memUnsigned;
  assign w_regWe    = w_wait ? r_regWrEnable : i_regWrEnable;
  assign w_regAddr  = w_wait ? r_regWrAddr   : i_regWrAddr;

  assign w_memOp = w_rd | w_wr;

  always_comb begin
    case (MemAccess'(w_access))
      BYTE:    w_misal = 1'b0;
      HALF:    w_misal = w_result[0];
      default: w_misal = (w_result[1:0] != 2'b00);
    endcase
  end

  assign w_issue   = w_idle & i_isValid & w_memOp & ~w_misal & ~i_flush;
  assign w_timeout = w_wait & (r_cnt == TMO);
  assign w_done    = w_wait & ~w_timeout & i_memReady;
  assign w_req     = w_issue | (w_wait & ~w_timeout);

  // Bus side
  assign o_memAddr     = {w_result[31:2], 2'b00};
  assign o_memRdEnable = ~i_reset & w_req & w_rd;
  assign o_memWrEnable = ~i_reset & w_req & w_wr;

  always_comb begin
    case (MemAccess'(w_access))
      BYTE: begin
        o_memByteEnable = 4'b0001 << w_result[1:0];
        o_memWrData     = {4{w_wrDataIn[7:0]}};
      end
      HALF: begin
        o_memByteEnable = 4'b0011 << {w_result[1], 1'b0};
        o_memWrData     = {2{w_wrDataIn[15:0]}};
      end
      default: begin
        o_memByteEnable = 4'b1111;
        o_memWrData     = w_wrDataIn;
      end
    endcase
  end

  mem_load_align u_align (
    .i_rdData   (i_memRdData),
    .i_offset   (w_result[1:0]),
    .i_access   (w_access),
    .i_unsigned (w_unsigned),
    .o_data     (w_ldData)
  );

  // Writeback side
  assign o_regWrAddr   = w_regAddr;
  assign o_regWrEnable = w_regWe & ~w_wr;
  assign o_regWrData   = w_rd ? w_ldData : w_result;

  assign o_isValid = ~i_reset & (
      (w_idle & i_isValid & ~i_flush & (~w_memOp | (w_issue & i_memReady))) |
      (w_done & ~r_flushPend & ~i_flush));
  assign o_stall      = ~i_reset & ((w_issue & ~i_memReady) | (w_wait & ~w_timeout & ~i_memReady));
  assign o_misaligned = ~i_reset & w_idle & i_isValid & w_memOp & w_misal & ~i_flush;
  assign o_busError   = ~i_reset & w_timeout;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_flushPend   <= 1'b0;
      r_result      <= '0;
      r_wrData      <= '0;
      r_access      <= '0;
      r_rd          <= 1'b0;
      r_wr          <= 1'b0;
      r_unsigned    <= 1'b0;
      r_regWrEnable <= 1'b0;
      r_regWrAddr   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_issue && !i_memReady) begin
            r_state       <= WAIT;
            r_cnt         <= '0;
            r_flushPend   <= 1'b0;
            r_result      <= i_result;
            r_wrData      <= i_memWrData;
            r_access      <= i_memAccess;
            r_rd          <= i_memRdEnable;
            r_wr          <= i_memWrEnable;
            r_unsigned    <= i_memUnsigned;
            r_regWrEnable <= i_regWrEnable;
            r_regWrAddr   <= i_regWrAddr;
          end
        end
        WAIT: begin
          if (i_flush) r_flushPend <= 1'b1;
          if (w_timeout || w_done) r_state <= IDLE;
          else                     r_cnt   <= r_cnt + 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: stimulus pushes expected writeback/exception events into a
// scoreboard queue, a negedge monitor pops and compares whenever the DUT presents one.
module tb_mem_stage;
  import Types::*;

  logic        clk = 1'b0;
  logic        i_reset, i_flush, i_isValid, i_regWrEnable;
  logic [4:0]  i_regWrAddr;
  logic [31:0] i_result, i_memWrData, i_memRdData;
  logic        i_memRdEnable, i_memWrEnable, i_memUnsigned, i_memReady;
  logic [1:0]  i_memAccess;
  logic [31:0] o_memAddr, o_memWrData, o_regWrData;
  logic        o_memRdEnable, o_memWrEnable, o_isValid, o_regWrEnable;
  logic        o_stall, o_misaligned, o_busError;
  logic [3:0]  o_memByteEnable;
  logic [4:0]  o_regWrAddr;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT(255)) dut (
    .i_clock(clk), .i_reset(i_reset), .i_flush(i_flush),
    .i_isValid(i_isValid), .i_regWrAddr(i_regWrAddr), .i_regWrEnable(i_regWrEnable),
    .i_result(i_result), .i_memRdEnable(i_memRdEnable), .i_memWrEnable(i_memWrEnable),
    .i_memAccess(i_memAccess), .i_memUnsigned(i_memUnsigned), .i_memWrData(i_memWrData),
    .o_memAddr(o_memAddr), .o_memRdEnable(o_memRdEnable), .o_memWrEnable(o_memWrEnable),
    .o_memByteEnable(o_memByteEnable), .o_memWrData(o_memWrData),
    .i_memRdData(i_memRdData), .i_memReady(i_memReady),
    .o_isValid(o_isValid), .o_regWrAddr(o_regWrAddr), .o_regWrEnable(o_regWrEnable),
    .o_regWrData(o_regWrData), .o_stall(o_stall), .o_misaligned(o_misaligned),
    .o_busError(o_busError)
  );

  // kind = {isValid, misaligned, busError}
  typedef struct {
    logic [2:0]  kind;
    logic        chk_data;
    logic [31:0] data;
    logic [4:0]  addr;
    logic        we;
  } exp_t;

  localparam logic [2:0] K_VALID = 3'b100, K_MIS = 3'b010, K_BERR = 3'b001;

  exp_t sb[$];
  exp_t m_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [2:0] k, input logic chk, input logic [31:0] d,
                      input logic [4:0] a, input logic we);
    exp_t e;
    e.kind = k; e.chk_data = chk; e.data = d; e.addr = a; e.we = we;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!i_reset && (o_isValid || o_misaligned || o_busError)) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_event: got v/m/b %b%b%b expected none",
                 o_isValid, o_misaligned, o_busError);
      end else begin
        m_e = sb.pop_front();
        check("event_kind", {29'd0, o_isValid, o_misaligned, o_busError}, {29'd0, m_e.kind});
        if (m_e.kind == K_VALID) begin
          check("regWrAddr", {27'd0, o_regWrAddr}, {27'd0, m_e.addr});
          check("regWrEnable", {31'd0, o_regWrEnable}, {31'd0, m_e.we});
          if (m_e.chk_data) check("regWrData", o_regWrData, m_e.data);
        end
      end
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic smp();  @(negedge clk);     endtask

  task automatic set_op(input logic v, input logic rd, input logic wr, input logic [1:0] acc,
                        input logic uns, input logic [31:0] res, input logic [31:0] wd,
                        input logic [4:0] ra, input logic rwe);
    i_isValid = v; i_memRdEnable = rd; i_memWrEnable = wr; i_memAccess = acc;
    i_memUnsigned = uns; i_result = res; i_memWrData = wd; i_regWrAddr = ra;
    i_regWrEnable = rwe;
  endtask

  task automatic idle();
    set_op(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
    i_flush = 1'b0; i_memReady = 1'b0; i_memRdData = 32'd0;
  endtask

  initial begin
    int n;
    idle();
    i_reset = 1'b1;
    // Reset state: a valid op presented during reset must not come out.
    set_op(1'b1, 1'b0, 1'b0, WORD, 1'b0, 32'h1234_5678, 32'd0, 5'd1, 1'b1);
    smp();
    check("rst_isValid", {31'd0, o_isValid}, 32'd0);
    check("rst_stall", {31'd0, o_stall}, 32'd0);
    check("rst_rdEn", {31'd0, o_memRdEnable}, 32'd0);
    tick();
    i_reset = 1'b0; idle();

    // Non-memory passthrough
    set_op(1'b1, 1'b0, 1'b0, WORD, 1'b0, 32'hDEAD_BEEF, 32'd0, 5'd7, 1'b1);
    push(K_VALID, 1'b1, 32'hDEAD_BEEF, 5'd7, 1'b1);
    smp();
    check("alu_stall", {31'd0, o_stall}, 32'd0);
    check("alu_req", {30'd0, o_memRdEnable, o_memWrEnable}, 32'd0);
    tick(); idle();

    // Word load, ready same cycle
    set_op(1'b1, 1'b1, 1'b0, WORD, 1'b0, 32'h0000_0100, 32'd0, 5'd3, 1'b1);
    i_memReady = 1'b1; i_memRdData = 32'h1122_3344;
    push(K_VALID, 1'b1, 32'h1122_3344, 5'd3, 1'b1);
    smp();
    check("lw_stall", {31'd0, o_stall}, 32'd0);
    check("lw_rdEn", {31'd0, o_memRdEnable}, 32'd1);
    check("lw_addr", o_memAddr, 32'h0000_0100);
    check("lw_be", {28'd0, o_memByteEnable}, 32'hF);
    tick(); idle();

    // Signed byte load at 0x103, ready after three stall cycles; inputs scrambled while waiting
    set_op(1'b1, 1'b1, 1'b0, BYTE, 1'b0, 32'h0000_0103, 32'd0, 5'd5, 1'b1);
    push(K_VALID, 1'b1, 32'hFFFF_FF80, 5'd5, 1'b1);
    i_memRdData = 32'h80FF_FFFF;
    n = 0;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) begin i_result = 32'hFFFF_FFFE; i_memAccess = WORD; i_regWrAddr = 5'd9; end
      if (c == 3) i_memReady = 1'b1;
      smp();
      if (o_stall) n++;
      check("lb_addr", o_memAddr, 32'h0000_0100);
      check("lb_be", {28'd0, o_memByteEnable}, 32'h8);
      tick();
    end
    check("lb_stall_cycles", n, 3);
    idle();

    // Half store at 0x202
    set_op(1'b1, 1'b0, 1'b1, HALF, 1'b0, 32'h0000_0202, 32'h0000_ABCD, 5'd4, 1'b1);
    i_memReady = 1'b1;
    push(K_VALID, 1'b0, 32'd0, 5'd4, 1'b0);
    smp();
    check("sh_be", {28'd0, o_memByteEnable}, 32'hC);
    check("sh_wdata", o_memWrData, 32'hABCD_ABCD);
    check("sh_req", {30'd0, o_memRdEnable, o_memWrEnable}, 32'd1);
    tick(); idle();

    // Byte store at 0x201
    set_op(1'b1, 1'b0, 1'b1, BYTE, 1'b0, 32'h0000_0201, 32'h0000_0012, 5'd4, 1'b0);
    i_memReady = 1'b1;
    push(K_VALID, 1'b0, 32'd0, 5'd4, 1'b0);
    smp();
    check("sb_be", {28'd0, o_memByteEnable}, 32'h2);
    check("sb_wdata", o_memWrData, 32'h1212_1212);
    tick(); idle();

    // Unsigned and signed half loads from the upper half
    set_op(1'b1, 1'b1, 1'b0, HALF, 1'b1, 32'h0000_0102, 32'd0, 5'd6, 1'b1);
    i_memReady = 1'b1; i_memRdData = 32'h8765_4321;
    push(K_VALID, 1'b1, 32'h0000_8765, 5'd6, 1'b1);
    smp(); tick();
    i_memUnsigned = 1'b0;
    push(K_VALID, 1'b1, 32'hFFFF_8765, 5'd6, 1'b1);
    smp(); tick(); idle();

    // Misaligned word load
    set_op(1'b1, 1'b1, 1'b0, WORD, 1'b0, 32'h0000_0101, 32'd0, 5'd2, 1'b1);
    i_memReady = 1'b1;
    push(K_MIS, 1'b0, 32'd0, 5'd0, 1'b0);
    smp();
    check("mis_rdEn", {31'd0, o_memRdEnable}, 32'd0);
    check("mis_stall", {31'd0, o_stall}, 32'd0);
    tick(); idle();

    // Flush in IDLE suppresses the request
    set_op(1'b1, 1'b1, 1'b0, WORD, 1'b0, 32'h0000_0100, 32'd0, 5'd2, 1'b1);
    i_flush = 1'b1; i_memReady = 1'b1;
    smp();
    check("flush_idle_rdEn", {31'd0, o_memRdEnable}, 32'd0);
    tick(); idle();

    // Bus timeout: request held for 256 cycles, then dropped with a bus error
    set_op(1'b1, 1'b1, 1'b0, WORD, 1'b0, 32'h0000_0300, 32'd0, 5'd8, 1'b1);
    push(K_BERR, 1'b0, 32'd0, 5'd0, 1'b0);
    n = 0;
    for (int k = 0; k < 1000; k++) begin
      smp();
      if (!o_memRdEnable) break;
      n++;
      tick();
    end
    check("tmo_req_cycles", n, 256);
    check("tmo_stall", {31'd0, o_stall}, 32'd0);
    tick(); idle();

    // Flush in WAIT: transfer completes but produces no valid
    set_op(1'b1, 1'b1, 1'b0, WORD, 1'b0, 32'h0000_0400, 32'd0, 5'd10, 1'b1);
    smp();
    check("fw_stall0", {31'd0, o_stall}, 32'd1);
    tick(); i_flush = 1'b1;
    smp();
    check("fw_stall1", {31'd0, o_stall}, 32'd1);
    tick(); i_flush = 1'b0;
    smp(); tick();
    i_memReady = 1'b1; i_memRdData = 32'h5555_AAAA;
    smp();
    check("fw_done_rdEn", {31'd0, o_memRdEnable}, 32'd1);
    check("fw_done_stall", {31'd0, o_stall}, 32'd0);
    tick(); idle();
    smp();
    check("fw_after_rdEn", {31'd0, o_memRdEnable}, 32'd0);
    tick();

    // Reset mid-WAIT drops the request asynchronously
    set_op(1'b1, 1'b1, 1'b0, WORD, 1'b0, 32'h0000_0500, 32'd0, 5'd11, 1'b1);
    smp(); tick();
    smp();
    check("rw_rdEn_before", {31'd0, o_memRdEnable}, 32'd1);
    #1 i_reset = 1'b1;
    #1;
    check("rw_rdEn_after", {31'd0, o_memRdEnable}, 32'd0);
    check("rw_stall_after", {31'd0, o_stall}, 32'd0);
    tick();
    i_reset = 1'b0; idle();

    // Back in IDLE: a same-cycle-ready load completes normally
    set_op(1'b1, 1'b1, 1'b0, WORD, 1'b0, 32'h0000_0104, 32'd0, 5'd12, 1'b1);
    i_memReady = 1'b1; i_memRdData = 32'hCAFE_F00D;
    push(K_VALID, 1'b1, 32'hCAFE_F00D, 5'd12, 1'b1);
    smp();
    check("post_rst_stall", {31'd0, o_stall}, 32'd0);
    tick(); idle();
    smp(); tick(); smp();

    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
